// File: rtl/alu_sequencer_if.sv
// Program-memory fetch port plus ALU control/flag bundle between the sequencer (master) and the
// memory/ALU side (slave).
interface alu_sequencer_if #(parameter int AW = 4);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [7:0]    imem_data;
    logic [2:0]    flgs;
    logic [3:0]    tin;
    logic [3:0]    pin;
    logic          uacc;
    logic          inmode;
    logic          outmode;
    logic [1:0]    cmode;
    logic          bus_valid;

    modport master (
        output imem_req, imem_addr, tin, pin, uacc, inmode, outmode, cmode, bus_valid,
        input  imem_ack, imem_data, flgs
    );

    modport slave (
        input  imem_req, imem_addr, tin, pin, uacc, inmode, outmode, cmode, bus_valid,
        output imem_ack, imem_data, flgs
    );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode sequencer for the 4-bit accumulator ALU; SEQ_SINGLE_STEP_EN adds a step input that
// gates each fetch. ALU controls are retimed on negedge clk so they are stable over each clk-high phase.
module alu_sequencer #(
    parameter int            AW         = 4,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic step,
`endif
    output logic halted,
    alu_sequencer_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    ir_q, ir_d;
    logic          req;
    logic          fire;
    logic          jump_taken;
    logic [3:0]    op;
    logic [3:0]    imm;

    logic [3:0] tin_q, tin_d;
    logic [3:0] pin_q, pin_d;
    logic [1:0] cmode_q, cmode_d;
    logic       inmode_q, inmode_d;
    logic       uacc_q, uacc_d;
    logic       outmode_q, outmode_d;
    logic       bus_valid_q, bus_valid_d;

    assign op  = ir_q[7:4];
    assign imm = ir_q[3:0];

`ifdef SEQ_SINGLE_STEP_EN
    // A step pulse arms exactly one fetch; the arm is consumed by the req&ack handshake.
    logic pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (state_q == S_FETCH && step) pend_d = 1'b1;
        if (fire)                       pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end

    assign req = (state_q == S_FETCH) && pend_q;
`else
    assign req = (state_q == S_FETCH);
`endif

    assign fire = req && bus.imem_ack;

    always_comb begin
        case (op)
            4'h7:    jump_taken = 1'b1;
            4'h8:    jump_taken = bus.flgs[0];
            4'h9:    jump_taken = bus.flgs[2];
            4'hA:    jump_taken = bus.flgs[1];
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: if (fire) begin
                ir_d    = bus.imem_data;
                pc_d    = pc_q + AW'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = (op == 4'hF) ? S_HALT : S_FETCH;
                if (jump_taken) begin
                    pc_d      = '0;
                    pc_d[3:0] = imm;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Operand/mode registers hold their last value outside the instructions that set them.
    always_comb begin
        tin_d       = tin_q;
        pin_d       = pin_q;
        cmode_d     = cmode_q;
        inmode_d    = inmode_q;
        uacc_d      = 1'b0;
        outmode_d   = 1'b1;
        bus_valid_d = 1'b0;
        if (state_q == S_EXEC) begin
            case (op)
                4'h1: begin
                    pin_d    = imm;
                    inmode_d = 1'b1;
                    uacc_d   = 1'b1;
                end
                4'h2, 4'h3, 4'h4, 4'h5: begin
                    tin_d    = imm;
                    inmode_d = 1'b0;
                    cmode_d  = op[1:0] - 2'd2;
                    uacc_d   = 1'b1;
                end
                4'h6: begin
                    outmode_d   = 1'b0;
                    bus_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            tin_q       <= 4'h0;
            pin_q       <= 4'h0;
            cmode_q     <= 2'b00;
            inmode_q    <= 1'b0;
            uacc_q      <= 1'b0;
            outmode_q   <= 1'b1;
            bus_valid_q <= 1'b0;
        end else begin
            tin_q       <= tin_d;
            pin_q       <= pin_d;
            cmode_q     <= cmode_d;
            inmode_q    <= inmode_d;
            uacc_q      <= uacc_d;
            outmode_q   <= outmode_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.tin       = tin_q;
    assign bus.pin       = pin_q;
    assign bus.cmode     = cmode_q;
    assign bus.inmode    = inmode_q;
    assign bus.uacc      = uacc_q;
    assign bus.outmode   = outmode_q;
    assign bus.bus_valid = bus_valid_q;
    assign halted        = (state_q == S_HALT);
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: program fetch/exec, memory wait, jumps, PC wrap, reset, HLT.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic halted;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    int uacc_cnt = 0;
    int bus_cnt = 0;

    alu_sequencer_if #(.AW(4)) bus ();

    alu_sequencer #(.AW(4), .START_ADDR(4'd0)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step   (step),
`endif
        .halted (halted),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.uacc === 1'b1)      uacc_cnt++;
        if (bus.bus_valid === 1'b1) bus_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one fetch at address a with data d after dly wait cycles; returns in the EXEC cycle.
    task automatic fetch(input logic [3:0] a, input logic [7:0] d, input int dly);
`ifdef SEQ_SINGLE_STEP_EN
        chk("step_wait_req", {7'd0, bus.imem_req}, 8'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
`endif
        chk("fetch_req", {7'd0, bus.imem_req}, 8'd1);
        chk("fetch_addr", {4'd0, bus.imem_addr}, {4'd0, a});
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("wait_req", {7'd0, bus.imem_req}, 8'd1);
            chk("wait_addr", {4'd0, bus.imem_addr}, {4'd0, a});
        end
        bus.imem_data = d;
        bus.imem_ack  = 1'b1;
        tick();
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;
        chk("exec_req_low", {7'd0, bus.imem_req}, 8'd0);
    endtask

    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;
        bus.flgs      = 3'b000;
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_req", {7'd0, bus.imem_req}, 8'd0);
        chk("rst_addr", {4'd0, bus.imem_addr}, 8'd0);
        chk("rst_uacc", {7'd0, bus.uacc}, 8'd0);
        chk("rst_inmode", {7'd0, bus.inmode}, 8'd0);
        chk("rst_outmode", {7'd0, bus.outmode}, 8'd1);
        chk("rst_cmode", {6'd0, bus.cmode}, 8'd0);
        chk("rst_tin", {4'd0, bus.tin}, 8'd0);
        chk("rst_pin", {4'd0, bus.pin}, 8'd0);
        chk("rst_bus_valid", {7'd0, bus.bus_valid}, 8'd0);
        chk("rst_halted", {7'd0, halted}, 8'd0);

        run = 1'b1;
        tick();
`ifdef SEQ_SINGLE_STEP_EN
        repeat (4) tick();
        chk("nostep_req", {7'd0, bus.imem_req}, 8'd0);
        chk("nostep_addr", {4'd0, bus.imem_addr}, 8'd0);
`endif

        // LDI 5; ADD 3; OUT (OUT fetch delayed 3 cycles)
        fetch(4'd0, 8'h15, 0);
        tick();
        chk("ldi_pin", {4'd0, bus.pin}, 8'd5);
        chk("ldi_inmode", {7'd0, bus.inmode}, 8'd1);
        chk("ldi_uacc", {7'd0, bus.uacc}, 8'd1);
        chk("ldi_next_addr", {4'd0, bus.imem_addr}, 8'd1);
        fetch(4'd1, 8'h23, 0);
        tick();
        chk("add_tin", {4'd0, bus.tin}, 8'd3);
        chk("add_cmode", {6'd0, bus.cmode}, 8'd0);
        chk("add_inmode", {7'd0, bus.inmode}, 8'd0);
        chk("add_uacc", {7'd0, bus.uacc}, 8'd1);
        chk("add_pin_held", {4'd0, bus.pin}, 8'd5);
        fetch(4'd2, 8'h60, 3);
        tick();
        chk("out_bus_valid", {7'd0, bus.bus_valid}, 8'd1);
        chk("out_outmode", {7'd0, bus.outmode}, 8'd0);
        chk("out_uacc", {7'd0, bus.uacc}, 8'd0);
        chk("uacc_pulses_2", uacc_cnt[7:0], 8'd2);
        tick();
        chk("out_bus_valid_drop", {7'd0, bus.bus_valid}, 8'd0);
        chk("out_outmode_restore", {7'd0, bus.outmode}, 8'd1);
        chk("bus_pulses_1", bus_cnt[7:0], 8'd1);

        // LDI 0; AND 0; JZ 9 with zero flag set -> taken
        fetch(4'd3, 8'h10, 0);
        tick();
        fetch(4'd4, 8'h30, 0);
        tick();
        chk("and_cmode", {6'd0, bus.cmode}, 8'd1);
        bus.flgs = 3'b001;
        fetch(4'd5, 8'h89, 0);
        tick();
        chk("jz_taken_addr", {4'd0, bus.imem_addr}, 8'd9);
        // Same sequence with flags clear -> falls through
        bus.flgs = 3'b000;
        fetch(4'd9, 8'h10, 0);
        tick();
        fetch(4'd10, 8'h30, 0);
        tick();
        fetch(4'd11, 8'h89, 0);
        tick();
        chk("jz_not_taken_addr", {4'd0, bus.imem_addr}, 8'd12);
        bus.flgs = 3'b100;
        fetch(4'd12, 8'h9E, 0);
        tick();
        chk("jc_taken_addr", {4'd0, bus.imem_addr}, 8'd14);
        bus.flgs = 3'b000;
        fetch(4'd14, 8'h7F, 0);
        tick();
        chk("jmp_addr", {4'd0, bus.imem_addr}, 8'd15);
        fetch(4'd15, 8'h00, 0);
        tick();
        chk("pc_wrap_addr", {4'd0, bus.imem_addr}, 8'd0);

        // LDI 7; XOR 6, then reset while waiting in FETCH
        fetch(4'd0, 8'h17, 0);
        tick();
        chk("ldi7_pin", {4'd0, bus.pin}, 8'd7);
        fetch(4'd1, 8'h56, 0);
        tick();
        chk("xor_tin", {4'd0, bus.tin}, 8'd6);
        chk("xor_cmode", {6'd0, bus.cmode}, 8'd3);
        chk("uacc_pulses_8", uacc_cnt[7:0], 8'd8);
        chk("pre_rst_addr", {4'd0, bus.imem_addr}, 8'd2);
        rst = 1'b1;
        #1;
        chk("midrst_req", {7'd0, bus.imem_req}, 8'd0);
        chk("midrst_addr", {4'd0, bus.imem_addr}, 8'd0);
        chk("midrst_tin", {4'd0, bus.tin}, 8'd0);
        chk("midrst_pin", {4'd0, bus.pin}, 8'd0);
        chk("midrst_cmode", {6'd0, bus.cmode}, 8'd0);
        chk("midrst_outmode", {7'd0, bus.outmode}, 8'd1);
        tick();
        rst = 1'b0;
        tick();

        // HLT: halted, no further fetches, run ignored
        fetch(4'd0, 8'hF0, 0);
        tick();
        chk("hlt_halted", {7'd0, halted}, 8'd1);
        chk("hlt_req", {7'd0, bus.imem_req}, 8'd0);
        run = 1'b0;
        tick();
        run = 1'b1;
        repeat (3) tick();
        chk("hlt_hold_halted", {7'd0, halted}, 8'd1);
        chk("hlt_hold_req", {7'd0, bus.imem_req}, 8'd0);
        chk("hlt_hold_addr", {4'd0, bus.imem_addr}, 8'd1);
        chk("uacc_pulses_final", uacc_cnt[7:0], 8'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
